// File: rtl/bounce_box_if.sv
// Pixel-stage bundle between vga_controller timing and the bounce_box renderer.
// master drives sync/video_on and receives the retimed sync and RGB; slave is bounce_box.
interface bounce_box_if;
  logic hsync;
  logic vsync;
  logic video_on;
  logic vga_hs;
  logic vga_vs;
  logic red;
  logic green;
  logic blue;

  modport master (
    output hsync, vsync, video_on,
    input  vga_hs, vga_vs, red, green, blue
  );

  modport slave (
    input  hsync, vsync, video_on,
    output vga_hs, vga_vs, red, green, blue
  );
endinterface

// File: rtl/bounce_box.sv
// Bouncing-square pattern generator fed by vga_controller timing; RGB and sync retimed by one clock.
// Optional white active-area border when the macro BOUNCE_BORDER_EN is defined.
module bounce_box #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BOX_SIZE        = 32,
  parameter int STEP            = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic         clk_25,
  input  logic         rst,
  bounce_box_if.slave  bus
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
  localparam logic [XW-1:0] X_ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  localparam logic [10:0] X_LIM  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

  localparam logic       SYNC_IDLE   = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [2:0] COLOUR_INIT = 3'b100;

  typedef enum logic [0:0] {
    ST_BLANK  = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Seven-step colour cycle; 000 is unreachable so the box never disappears.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b100:  n = 3'b010;
      3'b010:  n = 3'b001;
      3'b001:  n = 3'b110;
      3'b110:  n = 3'b011;
      3'b011:  n = 3'b101;
      3'b101:  n = 3'b111;
      3'b111:  n = 3'b100;
      default: n = 3'b100;
    endcase
    return n;
  endfunction

  // One axis of box motion, evaluated in 11 bits so pos+step cannot wrap.
  // Result packs {bounce, dir_neg, pos}.
  function automatic logic [12:0] axis_next(input logic [10:0] pos, input logic dir_neg,
                                            input logic [10:0] lim, input logic [10:0] step);
    logic [10:0] sum;
    logic [12:0] r;
    sum = pos + step;
    if (!dir_neg) begin
      if (sum >= lim) r = {1'b1, 1'b1, lim};
      else            r = {1'b0, 1'b0, sum};
    end else begin
      if (pos <= step) r = {1'b1, 1'b0, 11'd0};
      else             r = {1'b0, 1'b1, pos - step};
    end
    return r;
  endfunction

  state_t        state_r, state_nx_s;
  logic [XW-1:0] x_r, x_nx_s;
  logic [YW-1:0] y_r, y_nx_s;
  logic [10:0]   box_x_r, box_x_nx_s;
  logic [10:0]   box_y_r, box_y_nx_s;
  logic          dir_x_r, dir_x_nx_s;
  logic          dir_y_r, dir_y_nx_s;
  logic [2:0]    colour_r, colour_nx_s;
  logic          von_prev_r;
  logic          vga_hs_r, vga_vs_r;
  logic [2:0]    rgb_r, rgb_nx_s;

  logic          tick_s;
  logic          locked_s;
  logic          bounce_s;
  logic [12:0]   ax_s, ay_s;
  logic [10:0]   xe_s, ye_s;
  logic          inbox_s;
  logic          border_s;

  // vga_vs_r doubles as the previous vsync sample for frame-start detection.
  assign tick_s   = (bus.vsync != SYNC_IDLE) && (vga_vs_r == SYNC_IDLE);
  assign locked_s = (state_r == ST_LOCKED);

  assign bus.vga_hs = vga_hs_r;
  assign bus.vga_vs = vga_vs_r;
  assign bus.red    = rgb_r[2];
  assign bus.green  = rgb_r[1];
  assign bus.blue   = rgb_r[0];

  // Lock state register.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) state_r <= ST_BLANK;
    else     state_r <= state_nx_s;
  end

  // Stay black until the first full frame boundary has been seen.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_BLANK: begin
        if (tick_s) state_nx_s = ST_LOCKED;
        else        state_nx_s = ST_BLANK;
      end
      ST_LOCKED: state_nx_s = ST_LOCKED;
      default:   state_nx_s = ST_BLANK;
    endcase
  end

  // Pixel coordinate reconstruction from video_on and frame ticks, saturating at the active edge.
  always_comb begin
    x_nx_s = x_r;
    y_nx_s = y_r;
    if (tick_s) begin
      x_nx_s = X_ZERO;
      y_nx_s = Y_ZERO;
    end else if (bus.video_on) begin
      if (x_r != X_LAST) x_nx_s = x_r + X_ONE;
      else               x_nx_s = x_r;
    end else if (von_prev_r) begin
      x_nx_s = X_ZERO;
      if (y_r != Y_LAST) y_nx_s = y_r + Y_ONE;
      else               y_nx_s = y_r;
    end else begin
      x_nx_s = x_r;
      y_nx_s = y_r;
    end
  end

  // Box motion and colour; a simultaneous double bounce rotates the colour only once.
  always_comb begin
    ax_s        = axis_next(box_x_r, dir_x_r, X_LIM, STEP_W);
    ay_s        = axis_next(box_y_r, dir_y_r, Y_LIM, STEP_W);
    box_x_nx_s  = box_x_r;
    box_y_nx_s  = box_y_r;
    dir_x_nx_s  = dir_x_r;
    dir_y_nx_s  = dir_y_r;
    bounce_s    = 1'b0;
    colour_nx_s = colour_r;
    if (tick_s) begin
      box_x_nx_s = ax_s[10:0];
      dir_x_nx_s = ax_s[11];
      box_y_nx_s = ay_s[10:0];
      dir_y_nx_s = ay_s[11];
      bounce_s   = ax_s[12] | ay_s[12];
    end else begin
      bounce_s   = 1'b0;
    end
    if (bounce_s) colour_nx_s = next_colour(colour_r);
    else          colour_nx_s = colour_r;
  end

  // Pixel colour decision for the current coordinate.
  always_comb begin
    xe_s    = 11'(x_r);
    ye_s    = 11'(y_r);
    inbox_s = (xe_s >= box_x_r) && (xe_s < box_x_r + BOX_W) &&
              (ye_s >= box_y_r) && (ye_s < box_y_r + BOX_W);
`ifdef BOUNCE_BORDER_EN
    border_s = (x_r == X_ZERO) || (x_r == X_LAST) || (y_r == Y_ZERO) || (y_r == Y_LAST);
`else
    border_s = 1'b0;
`endif
    rgb_nx_s = 3'b000;
    if (bus.video_on && locked_s) begin
      if (border_s)     rgb_nx_s = 3'b111;
      else if (inbox_s) rgb_nx_s = colour_r;
      else              rgb_nx_s = 3'b000;
    end else begin
      rgb_nx_s = 3'b000;
    end
  end

  // Coordinate, box and colour state.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      x_r        <= X_ZERO;
      y_r        <= Y_ZERO;
      box_x_r    <= 11'd0;
      box_y_r    <= 11'd0;
      dir_x_r    <= 1'b0;
      dir_y_r    <= 1'b0;
      colour_r   <= COLOUR_INIT;
      von_prev_r <= 1'b0;
    end else begin
      x_r        <= x_nx_s;
      y_r        <= y_nx_s;
      box_x_r    <= box_x_nx_s;
      box_y_r    <= box_y_nx_s;
      dir_x_r    <= dir_x_nx_s;
      dir_y_r    <= dir_y_nx_s;
      colour_r   <= colour_nx_s;
      von_prev_r <= bus.video_on;
    end
  end

  // Output stage: RGB and sync share one register delay so they stay aligned.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      vga_hs_r <= SYNC_IDLE;
      vga_vs_r <= SYNC_IDLE;
      rgb_r    <= 3'b000;
    end else begin
      vga_hs_r <= bus.hsync;
      vga_vs_r <= bus.vsync;
      rgb_r    <= rgb_nx_s;
    end
  end

endmodule

// File: tb/tb_bounce_box.sv
// Directed bench for bounce_box: default 640x480 instance plus a square 640x640 instance
// whose box reaches both edges on the same frame tick.
module tb_bounce_box;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  bounce_box_if bif ();
  bounce_box_if bif2 ();

  assign bif2.hsync    = bif.hsync;
  assign bif2.vsync    = bif.vsync;
  assign bif2.video_on = bif.video_on;

  bounce_box dut (
    .clk_25 (clk),
    .rst    (rst),
    .bus    (bif.slave)
  );

  bounce_box #(.V_ACTIVE(640)) dut_sq (
    .clk_25 (clk),
    .rst    (rst),
    .bus    (bif2.slave)
  );

`ifdef BOUNCE_BORDER_EN
  localparam logic [2:0] BRD = 3'b111;
`else
  localparam logic [2:0] BRD = 3'b000;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] c1, c2;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rgb1();
    return {bif.red, bif.green, bif.blue};
  endfunction

  function automatic logic [2:0] rgb2();
    return {bif2.red, bif2.green, bif2.blue};
  endfunction

  task automatic frame();
    bif.vsync = 1'b0;
    cyc();
    cyc();
    bif.vsync = 1'b1;
    cyc();
  endtask

  // n active cycles; returned colours are the pixel at x=n-1 on the current line
  task automatic line(input int n, output logic [2:0] o1, output logic [2:0] o2);
    bif.video_on = 1'b1;
    repeat (n) cyc();
    o1 = rgb1();
    o2 = rgb2();
    bif.video_on = 1'b0;
    cyc();
  endtask

  task automatic skip(input int n);
    logic [2:0] a, b;
    for (int i = 0; i < n; i++) line(1, a, b);
  endtask

  initial begin
    rst          = 1'b1;
    bif.hsync    = 1'b1;
    bif.vsync    = 1'b1;
    bif.video_on = 1'b0;
    #30;
    chk("reset_rgb", rgb1(), 3'b000);
    chk("reset_hs", {2'b00, bif.vga_hs}, 3'b001);
    chk("reset_vs", {2'b00, bif.vga_vs}, 3'b001);
    #20 rst = 1'b0;
    cyc();

    // hsync passes through with exactly one clock of lag
    bif.hsync = 1'b0;
    chk("hs_before_edge", {2'b00, bif.vga_hs}, 3'b001);
    cyc();
    chk("hs_after_edge", {2'b00, bif.vga_hs}, 3'b000);
    bif.hsync = 1'b1;
    cyc();

    line(11, c1, c2);
    chk("unlocked_10_0", c1, 3'b000);

    // first frame tick with vsync lag checks; box moves to (2,2)
    bif.vsync = 1'b0;
    chk("vs_before_edge", {2'b00, bif.vga_vs}, 3'b001);
    cyc();
    chk("vs_after_edge", {2'b00, bif.vga_vs}, 3'b000);
    cyc();
    bif.vsync = 1'b1;
    cyc();
    chk("vs_release", {2'b00, bif.vga_vs}, 3'b001);

    line(33, c1, c2);
    chk("px_32_0", c1, BRD);
    line(2, c1, c2);
    chk("px_1_1", c1, 3'b000);
    skip(29);
    line(32, c1, c2);
    chk("px_31_31", c1, 3'b100);
    chk("sq_px_31_31", c2, 3'b100);
    line(1, c1, c2);
    chk("px_0_32", c1, BRD);
    line(34, c1, c2);
    chk("px_33_33", c1, 3'b100);
    line(35, c1, c2);
    chk("px_34_34", c1, 3'b000);
    skip(65);
    line(1, c1, c2);
    chk("px_0_100", c1, BRD);
    skip(378);
    line(640, c1, c2);
    chk("px_639_479", c1, BRD);
    chk("sq_px_639_479", c2, BRD);

    // tick 2: box at (4,4); overlong line must saturate x at 639
    frame();
    skip(10);
    bif.video_on = 1'b1;
    for (int i = 0; i < 700; i++) begin
      cyc();
      if (i == 10)  chk("sat_x10", rgb1(), 3'b100);
      if (i == 639) chk("sat_x639", rgb1(), BRD);
      if (i == 650) chk("sat_nowrap_650", rgb1(), BRD);
      if (i == 699) chk("sat_nowrap_699", rgb2(), BRD);
    end
    bif.video_on = 1'b0;
    cyc();

    // reset asserted mid-line inside the box
    bif.hsync    = 1'b0;
    bif.video_on = 1'b1;
    repeat (10) cyc();
    chk("pre_reset_px_9_11", rgb1(), 3'b100);
    chk("pre_reset_hs", {2'b00, bif.vga_hs}, 3'b000);
    #5 rst = 1'b1;
    #1;
    chk("async_reset_rgb", rgb1(), 3'b000);
    chk("async_reset_hs", {2'b00, bif.vga_hs}, 3'b001);
    chk("async_reset_vs", {2'b00, bif.vga_vs}, 3'b001);
    #10 rst = 1'b0;
    cyc();
    chk("post_reset_hs", {2'b00, bif.vga_hs}, 3'b000);
    repeat (4) cyc();
    chk("post_reset_black", rgb1(), 3'b000);
    bif.video_on = 1'b0;
    bif.hsync    = 1'b1;
    cyc();

    // ticks 1..302 after reset
    for (int i = 0; i < 302; i++) frame();

    // tick 303: default box (606,290) colour 010; square box (606,606) colour 100
    frame();
    skip(290);
    line(607, c1, c2);
    chk("t303_px_606_290", c1, 3'b010);
    chk("sq_t303_px_606_290", c2, 3'b000);
    skip(315);
    line(607, c1, c2);
    chk("t303_px_606_606", c1, BRD);
    chk("sq_t303_px_606_606", c2, 3'b100);

    // tick 304: default box (608,288) colour 001; square box (608,608) double bounce -> 010
    frame();
    skip(288);
    line(609, c1, c2);
    chk("t304_px_608_288", c1, 3'b001);
    chk("sq_t304_px_608_288", c2, 3'b000);
    skip(318);
    line(608, c1, c2);
    chk("sq_t304_px_607_607", c2, 3'b000);
    chk("t304_px_607_607", c1, BRD);
    line(609, c1, c2);
    chk("sq_t304_px_608_608", c2, 3'b010);
    chk("t304_px_608_608", c1, BRD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
